wfg_stim_dds: RTL and testbench
===============================

# wfg_stim_dds

Parametrised multi-waveform DDS stimulus generator: successor to the fixed sine stimulus, with configurable phase/output/LUT widths, four waveform modes, gain/offset scaling and full AXI-Stream backpressure. Sits between the register block (which drives the ctrl_* inputs) and the SPI driver, which consumes samples over the existing stim AXI-Stream interface.

## Interface
- OUTW, 18: output sample width (signed).
- PHASEW, 32: phase accumulator width.
- LUTAW, 8: quarter-wave sine LUT address bits (2^LUTAW entries).
- LUTDW, 16: LUT / raw waveform width (signed); full scale FS = 2^(LUTDW-1)-1.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- ctrl_en_i  in  1  generator enable.
- ctrl_mode_i  in  2  0 sine, 1 square, 2 sawtooth, 3 triangle.
- ctrl_inc_i  in  PHASEW  phase increment per sample.
- ctrl_phase_i  in  PHASEW  start phase, loaded on enable rise.
- ctrl_gain_i  in  16  unsigned Q2.14 gain (0x4000 = 1.0).
- ctrl_offset_i  in  OUTW  signed offset.
- wfg_stim_spi_tready_o  in  1  sink ready.
- wfg_stim_spi_tvalid_i  out  1  sample valid.
- wfg_stim_spi_tdata_i  out  OUTW  signed sample.

## Operation
- 3-stage pipeline S0 (phase) -> S1 (waveform) -> S2 (scale) -> output register; each stage carries a valid bit.
- Global advance = ~tvalid | tready; all stages hold when advance = 0. Data and valid in every stage stable while held.
- S0: en_q registers ctrl_en_i. If ctrl_en_i & advance: issue p = (~en_q ? ctrl_phase_i : phase_q) to S1 with valid; phase_q <= p + ctrl_inc_i (mod 2^PHASEW). If ctrl_en_i = 0: issue nothing (S1 valid cleared on advance); phase_q holds.
- Enable rise is detected from en_q; a rise during stall still loads ctrl_phase_i on the first issuing cycle.
- Disable does not flush: in-flight samples drain and are delivered.
- S1, with q = p[PHASEW-1:PHASEW-2], idx = p[PHASEW-3 -: LUTAW]:
  - sine: LUT index = q[0] ? ~idx : idx; value negated if q[1]. LUT[i] = round(FS*sin(pi/2*(i+0.5)/2^LUTAW)), registered read.
  - square: q[1] ? -FS : +FS.
  - sawtooth: {~p[PHASEW-1], p[PHASEW-2 -: LUTDW-1]} as signed (phase 0 -> -2^(LUTDW-1)).
  - triangle: t = p[PHASEW-2 -: LUTDW]; u = p[PHASEW-1] ? ~t : t; value = u with MSB inverted, as signed.
- S2: y = ((raw * gain) >>> 14) + offset, computed at LUTDW+18 bits signed, arithmetic shift, then reduced to OUTW (see Configuration).
- ctrl_mode_i, ctrl_gain_i, ctrl_offset_i, ctrl_inc_i sampled when the relevant stage advances; changes never corrupt in-flight samples already past that stage.

## Timing
- Reset: phase_q = 0, en_q = 0, all valids 0, wfg_stim_spi_tvalid_i = 0, wfg_stim_spi_tdata_i = 0. Reset mid-stream discards all in-flight samples with no further transfer.
- Latency: ctrl_en_i first sampled high at edge E -> tvalid high after edge E+3, data from ctrl_phase_i.
- Throughput: one sample per cycle with tready high continuously.
- Transfer on tvalid & tready at the rising edge; next sample presented in the same cycle if the pipeline is full.
- tvalid never drops without a transfer; tdata never changes while tvalid & ~tready.
- Phase wrap-around is silent modulo 2^PHASEW.

## Configuration
- WFG_STIM_DDS_SATURATE_EN defined: S2 result clamped to [-2^(OUTW-1), 2^(OUTW-1)-1].
- Not defined: S2 result truncated to the low OUTW bits (two's-complement wrap); no clamp logic synthesised.

## Test plan
- Sine, gain 0x4000, offset 0, inc 0x40000000, phase 0, tready=1 -> tdata 101, 32767, -101, -32767 repeating, first tvalid 3 cycles after enable.
- Sawtooth, inc 0x10000000, tready low 5 cycles after the 2nd transfer -> sequence -32768, -28672, -24576, ... with no loss/duplication; tdata stable during stall.
- Triangle, inc 0x20000000 -> -32768, -16384, 0, 16384, 32767, 16383, ...
- Square, gain 0x8000, offset 100000 -> 131071 with WFG_STIM_DDS_SATURATE_EN, -96610 without; -FS half-cycle gives 34466.
- Disable after 4 issued samples with tready=0, then release tready -> all in-flight samples delivered, then tvalid=0; re-enable with phase 0x80000000 restarts sine at -101.
- Assert wb_rst_i mid-stream with tvalid=1 -> next cycle tvalid=0, tdata=0; no transfer until re-enabled.

Source files
------------

// File: rtl/wfg_stim_dds_if.sv
// Stimulus AXI-Stream link between the DDS generator (master) and the SPI driver (slave).
// Signal names keep the historical SPI-driver-side suffixes, so tvalid/tdata carry _i and
// tready carries _o even though the generator drives tvalid/tdata.
interface wfg_stim_dds_if #(
    parameter int unsigned OUTW = 18
) ();

    logic            wfg_stim_spi_tvalid_i;
    logic [OUTW-1:0] wfg_stim_spi_tdata_i;
    logic            wfg_stim_spi_tready_o;

    modport master (
        output wfg_stim_spi_tvalid_i,
        output wfg_stim_spi_tdata_i,
        input  wfg_stim_spi_tready_o
    );

    modport slave (
        input  wfg_stim_spi_tvalid_i,
        input  wfg_stim_spi_tdata_i,
        output wfg_stim_spi_tready_o
    );

endinterface

// File: rtl/wfg_stim_dds.sv
// Multi-waveform DDS stimulus generator.
// Pipeline: S0 phase accumulator -> S1 waveform (sine LUT / square / saw / triangle)
// -> S2 gain/offset scaling -> AXI-Stream output register. A single advance signal
// (~tvalid | tready) moves every stage, so the whole pipe freezes under backpressure.
// Build option: define WFG_STIM_DDS_SATURATE_EN to clamp the scaled result to the OUTW
// range; otherwise the result wraps to the low OUTW bits.
module wfg_stim_dds #(
    parameter int unsigned OUTW   = 18,
    parameter int unsigned PHASEW = 32,
    parameter int unsigned LUTAW  = 8,
    parameter int unsigned LUTDW  = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ctrl_en_i,
    input  logic [1:0]        ctrl_mode_i,
    input  logic [PHASEW-1:0] ctrl_inc_i,
    input  logic [PHASEW-1:0] ctrl_phase_i,
    input  logic [15:0]       ctrl_gain_i,
    input  logic [OUTW-1:0]   ctrl_offset_i,
    wfg_stim_dds_if.master    stim_spi_io
);

    // Scaling is done at LUTDW+18 bits: 16-bit unsigned gain plus sign and headroom.
    localparam int unsigned ProdW    = LUTDW + 18;
    localparam int unsigned LutDepth = 2 ** LUTAW;

    localparam logic [1:0] ModeSine   = 2'd0;
    localparam logic [1:0] ModeSquare = 2'd1;
    localparam logic [1:0] ModeSaw    = 2'd2;
    localparam logic [1:0] ModeTri    = 2'd3;

    // +FS = 2^(LUTDW-1)-1 and its two's-complement negation.
    localparam logic [LUTDW-1:0] FsPos = {1'b0, {(LUTDW - 1){1'b1}}};
    localparam logic [LUTDW-1:0] FsNeg = {1'b1, {(LUTDW - 2){1'b0}}, 1'b1};

    // Quarter-wave entry i = round(FS * sin(pi/2 * (i + 0.5) / 2^LUTAW)), built at
    // elaboration with a Taylor series so the table follows LUTAW/LUTDW.
    function automatic logic [LUTDW-1:0] sine_entry(input int unsigned i);
        real x;
        real term;
        real acc;
        real fs;
        x    = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(LutDepth);
        term = x;
        acc  = x;
        for (int k = 1; k <= 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        fs = (2.0 ** (LUTDW - 1)) - 1.0;
        return LUTDW'($rtoi(fs * acc + 0.5));
    endfunction

    logic [LUTDW-1:0] sine_lut [LutDepth];

    for (genvar gi = 0; gi < LutDepth; gi++) begin : g_lut
        localparam logic [LUTDW-1:0] Entry = sine_entry(gi);
        assign sine_lut[gi] = Entry;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            tvalid_q, tvalid_d;
    logic [OUTW-1:0] tdata_q, tdata_d;
    logic            tready;
    logic            advance;

    assign tready  = stim_spi_io.wfg_stim_spi_tready_o;
    assign advance = ~tvalid_q | tready;

    assign stim_spi_io.wfg_stim_spi_tvalid_i = tvalid_q;
    assign stim_spi_io.wfg_stim_spi_tdata_i  = tdata_q;

    // ------------------------------------------------------------------
    // S0: phase accumulator
    // ------------------------------------------------------------------
    logic              en_q, en_d;
    logic [PHASEW-1:0] phase_q, phase_d;
    logic              s1_valid_q, s1_valid_d;
    logic [PHASEW-1:0] s1_phase_q, s1_phase_d;
    logic [PHASEW-1:0] issue_phase;

    // en_q only moves on advance, so an enable rise seen during a stall still
    // loads the start phase on the first cycle that actually issues.
    always_comb begin
        en_d        = en_q;
        phase_d     = phase_q;
        s1_valid_d  = s1_valid_q;
        s1_phase_d  = s1_phase_q;
        issue_phase = en_q ? phase_q : ctrl_phase_i;
        if (advance) begin
            en_d       = ctrl_en_i;
            s1_valid_d = ctrl_en_i;
            if (ctrl_en_i) begin
                s1_phase_d = issue_phase;
                phase_d    = issue_phase + ctrl_inc_i;
            end
        end
    end

    // S0 state registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_q       <= 1'b0;
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
        end else begin
            en_q       <= en_d;
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_phase_q <= s1_phase_d;
        end
    end

    // ------------------------------------------------------------------
    // S1: waveform generation
    // ------------------------------------------------------------------
    logic [1:0]       quad;
    logic [LUTAW-1:0] idx;
    logic [LUTAW-1:0] lut_addr;
    logic [LUTDW-1:0] lut_val;
    logic [LUTDW-1:0] tri_t;
    logic [LUTDW-1:0] tri_u;
    logic [LUTDW-1:0] raw_d;
    logic [LUTDW-1:0] s2_raw_q;
    logic             s2_valid_q, s2_valid_d;

    // Quadrant folding of the quarter-wave table plus the three arithmetic shapes.
    always_comb begin
        quad       = s1_phase_q[PHASEW-1 -: 2];
        idx        = s1_phase_q[PHASEW-3 -: LUTAW];
        lut_addr   = quad[0] ? ~idx : idx;
        lut_val    = sine_lut[lut_addr];
        tri_t      = s1_phase_q[PHASEW-2 -: LUTDW];
        tri_u      = s1_phase_q[PHASEW-1] ? ~tri_t : tri_t;
        raw_d      = s2_raw_q;
        s2_valid_d = s2_valid_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            case (ctrl_mode_i)
                ModeSine:   raw_d = quad[1] ? (~lut_val + LUTDW'(1)) : lut_val;
                ModeSquare: raw_d = quad[1] ? FsNeg : FsPos;
                ModeSaw:    raw_d = {~s1_phase_q[PHASEW-1], s1_phase_q[PHASEW-2 -: LUTDW-1]};
                ModeTri:    raw_d = {~tri_u[LUTDW-1], tri_u[LUTDW-2:0]};
                default:    raw_d = s2_raw_q;
            endcase
        end
    end

    // S1 output registers (this is also the registered LUT read).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s2_valid_q <= 1'b0;
            s2_raw_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_raw_q   <= raw_d;
        end
    end

    // ------------------------------------------------------------------
    // S2: gain (Q2.14) and offset
    // ------------------------------------------------------------------
    logic signed [ProdW-1:0] raw_ext;
    logic signed [ProdW-1:0] gain_ext;
    logic signed [ProdW-1:0] off_ext;
    logic signed [ProdW-1:0] prod;
    logic signed [ProdW-1:0] shifted;
    logic signed [ProdW-1:0] sum;
    logic [OUTW-1:0]         scaled;
    logic                    s3_valid_q, s3_valid_d;
    logic [OUTW-1:0]         s3_data_q, s3_data_d;

`ifdef WFG_STIM_DDS_SATURATE_EN
    localparam logic signed [ProdW-1:0] SatMax = {{(ProdW - OUTW + 1){1'b0}}, {(OUTW - 1){1'b1}}};
    localparam logic signed [ProdW-1:0] SatMin = {{(ProdW - OUTW + 1){1'b1}}, {(OUTW - 1){1'b0}}};
`endif

    // Signed raw times unsigned gain, arithmetic shift back to unity, then offset.
    always_comb begin
        raw_ext  = {{(ProdW - LUTDW){s2_raw_q[LUTDW-1]}}, s2_raw_q};
        gain_ext = {{(ProdW - 16){1'b0}}, ctrl_gain_i};
        off_ext  = {{(ProdW - OUTW){ctrl_offset_i[OUTW-1]}}, ctrl_offset_i};
        prod     = raw_ext * gain_ext;
        shifted  = prod >>> 14;
        sum      = shifted + off_ext;
`ifdef WFG_STIM_DDS_SATURATE_EN
        if (sum > SatMax) begin
            scaled = SatMax[OUTW-1:0];
        end else if (sum < SatMin) begin
            scaled = SatMin[OUTW-1:0];
        end else begin
            scaled = sum[OUTW-1:0];
        end
`else
        scaled = sum[OUTW-1:0];
`endif
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        if (advance) begin
            s3_valid_d = s2_valid_q;
            s3_data_d  = scaled;
        end
    end

    // S2 output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
        end else begin
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register: holds data and valid until the sink accepts.
    // ------------------------------------------------------------------
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        if (advance) begin
            tvalid_d = s3_valid_q;
            tdata_d  = s3_data_q;
        end
    end

    // AXI-Stream output registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    // Phase bits below the waveform windows and the discarded product bits.
    logic unused_bits;
    assign unused_bits = ^{s1_phase_q, prod, sum};

endmodule

// File: tb/tb_wfg_stim_dds.sv
// Directed self-checking bench for wfg_stim_dds.
module tb_wfg_stim_dds;

    localparam int OUTW   = 18;
    localparam int PHASEW = 32;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              ctrl_en_i;
    logic [1:0]        ctrl_mode_i;
    logic [PHASEW-1:0] ctrl_inc_i;
    logic [PHASEW-1:0] ctrl_phase_i;
    logic [15:0]       ctrl_gain_i;
    logic [OUTW-1:0]   ctrl_offset_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wfg_stim_dds_if #(.OUTW(OUTW)) stim_if ();

    wfg_stim_dds #(
        .OUTW  (OUTW),
        .PHASEW(PHASEW),
        .LUTAW (8),
        .LUTDW (16)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .ctrl_en_i    (ctrl_en_i),
        .ctrl_mode_i  (ctrl_mode_i),
        .ctrl_inc_i   (ctrl_inc_i),
        .ctrl_phase_i (ctrl_phase_i),
        .ctrl_gain_i  (ctrl_gain_i),
        .ctrl_offset_i(ctrl_offset_i),
        .stim_spi_io  (stim_if)
    );

    logic signed [OUTW-1:0] got;
    logic                   tvalid;
    assign got    = stim_if.wfg_stim_spi_tdata_i;
    assign tvalid = stim_if.wfg_stim_spi_tvalid_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic configure(input logic [1:0] mode, input logic [31:0] inc,
                             input logic [31:0] phase, input logic [15:0] gain,
                             input int offset);
        ctrl_mode_i   = mode;
        ctrl_inc_i    = inc;
        ctrl_phase_i  = phase;
        ctrl_gain_i   = gain;
        ctrl_offset_i = OUTW'(offset);
    endtask

    task automatic drain();
        ctrl_en_i = 1'b0;
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        wb_rst_i  = 1'b1;
        ctrl_en_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b expected 0", tvalid);
        end
        n_checks++;
        if (got !== OUTW'(0)) begin
            n_fail++; $display("FAIL reset_tdata: got %0d expected 0", got);
        end
        wb_rst_i = 1'b0;
        tick();
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL idle_tvalid: got %b expected 0", tvalid);
        end
    endtask

    task automatic test_sine();
        int exp_v [4] = '{101, 32767, -101, -32767};
        configure(2'd0, 32'h4000_0000, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        ctrl_en_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (tvalid !== 1'b0) begin
                n_fail++; $display("FAIL sine_latency%0d: tvalid got %b expected 0", c, tvalid);
            end
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (tvalid !== 1'b1 || got !== OUTW'(exp_v[k % 4])) begin
                n_fail++;
                $display("FAIL sine_s%0d: got v=%b d=%0d expected v=1 d=%0d",
                         k, tvalid, got, exp_v[k % 4]);
            end
            tick();
        end
        drain();
        n_checks++;
        if (tvalid !== 1'b0) begin
            n_fail++; $display("FAIL sine_drain: tvalid got %b expected 0", tvalid);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bit stalled = 0;
        logic signed [OUTW-1:0] held;
        configure(2'd2, 32'h1000_0000, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        ctrl_en_i = 1'b1;
        for (int c = 0; c < 60 && k < 8; c++) begin
            if (tvalid && stim_if.wfg_stim_spi_tready_o) begin
                n_checks++;
                if (got !== OUTW'(-32768 + 4096 * k)) begin
                    n_fail++;
                    $display("FAIL saw_s%0d: got %0d expected %0d", k, got, -32768 + 4096 * k);
                end
                k++;
            end
            tick();
            if (k == 2 && !stalled) begin
                stalled = 1;
                stim_if.wfg_stim_spi_tready_o = 1'b0;
                held = got;
                n_checks++;
                if (tvalid !== 1'b1 || held !== OUTW'(-24576)) begin
                    n_fail++;
                    $display("FAIL saw_stall_entry: got v=%b d=%0d expected v=1 d=-24576",
                             tvalid, held);
                end
                for (int s = 0; s < 5; s++) begin
                    tick();
                    n_checks++;
                    if (tvalid !== 1'b1 || got !== held) begin
                        n_fail++;
                        $display("FAIL saw_stall%0d: got v=%b d=%0d expected v=1 d=%0d",
                                 s, tvalid, got, held);
                    end
                end
                stim_if.wfg_stim_spi_tready_o = 1'b1;
            end
        end
        n_checks++;
        if (k != 8) begin
            n_fail++; $display("FAIL saw_count: got %0d transfers expected 8", k);
        end
        drain();
    endtask

    task automatic test_triangle();
        int exp_v [8] = '{-32768, -16384, 0, 16384, 32767, 16383, -1, -16385};
        int k = 0;
        configure(2'd3, 32'h2000_0000, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        ctrl_en_i = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            if (tvalid) begin
                n_checks++;
                if (got !== OUTW'(exp_v[k])) begin
                    n_fail++; $display("FAIL tri_s%0d: got %0d expected %0d", k, got, exp_v[k]);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 8) begin
            n_fail++; $display("FAIL tri_count: got %0d transfers expected 8", k);
        end
        drain();
    endtask

    task automatic test_square();
        int k = 0;
        int exp_v [2];
`ifdef WFG_STIM_DDS_SATURATE_EN
        exp_v[0] = 131071;
`else
        exp_v[0] = -96610;
`endif
        exp_v[1] = 34466;
        configure(2'd1, 32'h8000_0000, 32'h0, 16'h8000, 100000);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        ctrl_en_i = 1'b1;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (tvalid) begin
                n_checks++;
                if (got !== OUTW'(exp_v[k % 2])) begin
                    n_fail++;
                    $display("FAIL square_s%0d: got %0d expected %0d", k, got, exp_v[k % 2]);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 4) begin
            n_fail++; $display("FAIL square_count: got %0d transfers expected 4", k);
        end
        drain();
    endtask

    task automatic test_disable();
        int exp_a [4] = '{101, 32767, -101, -32767};
        int exp_b [4] = '{-101, -32767, 101, 32767};
        int k = 0;
        configure(2'd0, 32'h4000_0000, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b0;
        ctrl_en_i = 1'b1;
        repeat (4) tick();
        ctrl_en_i = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (tvalid !== 1'b1 || got !== OUTW'(101)) begin
            n_fail++; $display("FAIL dis_hold: got v=%b d=%0d expected v=1 d=101", tvalid, got);
        end
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (tvalid) begin
                n_checks++;
                if (k >= 4 || got !== OUTW'(exp_a[k])) begin
                    n_fail++;
                    $display("FAIL dis_s%0d: got %0d expected %0d", k, got, (k < 4) ? exp_a[k] : 0);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 4 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_count: got %0d transfers v=%b expected 4 v=0", k, tvalid);
        end
        // Re-enable at half-turn phase.
        ctrl_phase_i = 32'h8000_0000;
        ctrl_en_i    = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            if (tvalid) begin
                n_checks++;
                if (got !== OUTW'(exp_b[k])) begin
                    n_fail++; $display("FAIL reen_s%0d: got %0d expected %0d", k, got, exp_b[k]);
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 4) begin
            n_fail++; $display("FAIL reen_count: got %0d transfers expected 4", k);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        int w = 0;
        bit bad = 0;
        configure(2'd0, 32'h4000_0000, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        ctrl_en_i = 1'b1;
        while (!tvalid && w < 10) begin
            tick();
            w++;
        end
        tick();
        n_checks++;
        if (tvalid !== 1'b1) begin
            n_fail++; $display("FAIL mid_stream_live: tvalid got %b expected 1", tvalid);
        end
        wb_rst_i  = 1'b1;
        ctrl_en_i = 1'b0;
        tick();
        n_checks++;
        if (tvalid !== 1'b0 || got !== OUTW'(0)) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%0d expected v=0 d=0", tvalid, got);
        end
        wb_rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (tvalid !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL mid_quiet: tvalid got 1 expected 0 after reset");
        end
        ctrl_en_i = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (tvalid !== 1'b1 || got !== OUTW'(101)) begin
            n_fail++;
            $display("FAIL mid_restart: got v=%b d=%0d expected v=1 d=101", tvalid, got);
        end
        drain();
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        ctrl_en_i = 1'b0;
        configure(2'd0, 32'h0, 32'h0, 16'h4000, 0);
        stim_if.wfg_stim_spi_tready_o = 1'b1;
        test_reset();
        test_sine();
        test_backpressure();
        test_triangle();
        test_square();
        test_disable();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
